// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer and its control store / datapath: control-word
// fields and status in, micro-PC and register selects out.
interface micro_sequencer_if;
    logic [4:0]  NXTADD;
    logic        BR;
    logic        Z;
    logic        MEMREAD;
    logic        MEMWR;
    logic        MEMDONE;
    logic [15:0] IR;
    logic [4:0]  ROMADDR;
    logic [3:0]  WR;
    logic [3:0]  RR;
    logic        STALL;
    logic        HALTED;
    logic        MEMERR;

    modport slave (
        input  NXTADD, BR, Z, MEMREAD, MEMWR, MEMDONE, IR,
        output ROMADDR, WR, RR, STALL, HALTED, MEMERR
    );

    modport master (
        output NXTADD, BR, Z, MEMREAD, MEMWR, MEMDONE, IR,
        input  ROMADDR, WR, RR, STALL, HALTED, MEMERR
    );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: next-address selection, opcode dispatch, memory-wait stalling
// with timeout, and a terminal HALT state.
module micro_sequencer #(
    parameter logic [4:0] FETCH_ADDR  = 5'd0,
    parameter logic [4:0] DISP_BASE   = 5'd2,
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic                  clk,
    input  logic                  rstn,
    micro_sequencer_if.slave      bus
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0] state_reg, state_next;
    logic [4:0] upc_reg, upc_next;
    logic [3:0] wr_reg, wr_next;
    logic [3:0] rr_reg, rr_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       memerr_reg, memerr_next;

    logic [4:0] opcode;
    logic       access;
    logic       dispatch;
    logic       halt_op;
    logic       take_next;
    logic [4:0] next_addr;
    logic       unused_ir;

    assign opcode    = bus.IR[15:11];
    assign access    = bus.MEMREAD | bus.MEMWR;
    assign dispatch  = !bus.BR && (bus.NXTADD == 5'd31);
    assign halt_op   = (opcode == 5'b11111);
    assign unused_ir = ^bus.IR[10:8];

    // 5-bit arithmetic gives the mod-32 wrap for both increment and dispatch.
    always_comb begin
        next_addr = bus.NXTADD;
        if (bus.BR) begin
            next_addr = bus.Z ? bus.NXTADD : upc_reg + 5'd1;
        end else if (dispatch) begin
            next_addr = opcode + DISP_BASE;
        end
    end

    always_comb begin
        state_next  = state_reg;
        upc_next    = upc_reg;
        wr_next     = wr_reg;
        rr_next     = rr_reg;
        cnt_next    = cnt_reg;
        memerr_next = memerr_reg;
        take_next   = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (access && !bus.MEMDONE) begin
                    state_next = ST_WAIT;
                    cnt_next   = 8'd1;
                end else begin
                    take_next = 1'b1;
                end
            end
            ST_WAIT: begin
                // Completion takes priority over an expiring timeout.
                if (bus.MEMDONE) begin
                    cnt_next  = 8'd0;
                    take_next = 1'b1;
                end else if (cnt_reg == MEM_TIMEOUT) begin
                    state_next  = ST_RUN;
                    upc_next    = FETCH_ADDR;
                    memerr_next = 1'b1;
                    cnt_next    = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (take_next) begin
            if (dispatch && halt_op) begin
                state_next = ST_HALT;
            end else begin
                state_next = ST_RUN;
                upc_next   = next_addr;
                if (dispatch) begin
                    wr_next = bus.IR[7:4];
                    rr_next = bus.IR[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_RUN;
            upc_reg    <= FETCH_ADDR;
            wr_reg     <= 4'd0;
            rr_reg     <= 4'd0;
            cnt_reg    <= 8'd0;
            memerr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            upc_reg    <= upc_next;
            wr_reg     <= wr_next;
            rr_reg     <= rr_next;
            cnt_reg    <= cnt_next;
            memerr_reg <= memerr_next;
        end
    end

    assign bus.ROMADDR = upc_reg;
    assign bus.WR      = wr_reg;
    assign bus.RR      = rr_reg;
    assign bus.STALL   = (state_reg == ST_WAIT);
    assign bus.HALTED  = (state_reg == ST_HALT);
    assign bus.MEMERR  = memerr_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the driver queues expected outputs per cycle,
// a monitor pops and compares them at the negedge (or on demand for async reset).
module tb_micro_sequencer;

    logic clk;
    logic rstn;
    int   cycle;
    int   n_checks;
    int   n_pass;

    micro_sequencer_if bus();

    micro_sequencer #(
        .FETCH_ADDR (5'd0),
        .DISP_BASE  (5'd2),
        .MEM_TIMEOUT(8'd4)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        string       tag;
        logic [4:0]  rom;
        logic [3:0]  wr;
        logic [3:0]  rr;
        logic        stall;
        logic        halted;
        logic        memerr;
    } exp_t;

    exp_t exp_q[$];
    event async_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    task automatic check(input string tag, input string field, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s.%s actual=%0h required=%0h (t=%0t)", tag, field, act, req, $time);
    endtask

    // Monitor: pops every expectation due by the current cycle.
    initial begin
        forever begin
            @(negedge clk or async_chk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("cyc %0d %-10s rom=%0d wr=%0h rr=%0h stall=%0b halted=%0b memerr=%0b",
                         cycle, e.tag, bus.ROMADDR, bus.WR, bus.RR, bus.STALL, bus.HALTED, bus.MEMERR);
                check(e.tag, "rom",    int'(bus.ROMADDR), int'(e.rom));
                check(e.tag, "wr",     int'(bus.WR),      int'(e.wr));
                check(e.tag, "rr",     int'(bus.RR),      int'(e.rr));
                check(e.tag, "stall",  int'(bus.STALL),   int'(e.stall));
                check(e.tag, "halted", int'(bus.HALTED),  int'(e.halted));
                check(e.tag, "memerr", int'(bus.MEMERR),  int'(e.memerr));
            end
        end
    end

    function automatic exp_t mk(input int cyc, input string tag, input logic [4:0] rom,
                                input logic [3:0] wr, input logic [3:0] rr, input logic stall,
                                input logic halted, input logic memerr);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.rom = rom; e.wr = wr; e.rr = rr;
        e.stall = stall; e.halted = halted; e.memerr = memerr;
        return e;
    endfunction

    // Called just after a negedge: apply inputs, expect outputs after the next posedge.
    task automatic drive(input string tag, input logic [4:0] nxt, input logic br, input logic z,
                         input logic mr, input logic mw, input logic md, input logic [15:0] ir,
                         input logic [4:0] rom, input logic [3:0] wr, input logic [3:0] rr,
                         input logic stall, input logic halted, input logic memerr);
        bus.NXTADD = nxt; bus.BR = br; bus.Z = z;
        bus.MEMREAD = mr; bus.MEMWR = mw; bus.MEMDONE = md; bus.IR = ir;
        exp_q.push_back(mk(cycle + 1, tag, rom, wr, rr, stall, halted, memerr));
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.NXTADD = 5'd0; bus.BR = 1'b0; bus.Z = 1'b0;
        bus.MEMREAD = 1'b0; bus.MEMWR = 1'b0; bus.MEMDONE = 1'b0; bus.IR = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rstn     = 1'b0;
        idle_inputs();

        #2;
        exp_q.push_back(mk(cycle, "reset", 5'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        -> async_chk;
        @(negedge clk);
        #1;
        rstn = 1'b1;

        // Next-address selection and wrap
        drive("nxt7",    5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'd7,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive("nxt9",    5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'd9,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive("br_inc",  5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'd10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive("br_to31", 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 5'd31, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive("br_wrap", 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'd0,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive("br_take", 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 5'd20, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Memory wait of three stall cycles, then zero-wait access
        for (int i = 0; i < 3; i++)
            drive("mrd_wait", 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 5'd20, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive("mrd_done", 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 5'd12, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive("mrd_zero", 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 5'd3,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Timeout: four stall cycles, then fetch address with sticky error
        for (int i = 0; i < 4; i++)
            drive("mwr_wait", 5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 5'd3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive("mwr_tmo",  5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 5'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive("sticky",   5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'd6, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Async reset mid-wait with CNT=2, between clock edges
        for (int i = 0; i < 2; i++)
            drive("pre_rst", 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 5'd6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.push_back(mk(cycle, "async_rst", 5'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        -> async_chk;
        @(negedge clk);
        #1;
        idle_inputs();
        rstn = 1'b1;

        // Completion on the timeout edge wins; no error
        for (int i = 0; i < 4; i++)
            drive("race_wait", 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 5'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive("race_done", 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 5'd17, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Dispatch, dispatch at memory completion, then HALT
        drive("disp",      5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1853, 5'd5, 4'h5, 4'h3, 1'b0, 1'b0, 1'b0);
        drive("disp_wait", 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2000, 5'd5, 4'h5, 4'h3, 1'b1, 1'b0, 1'b0);
        drive("disp_mem",  5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h30A7, 5'd8, 4'hA, 4'h7, 1'b0, 1'b0, 1'b0);
        drive("halt",      5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF800, 5'd8, 4'hA, 4'h7, 1'b0, 1'b1, 1'b0);
        drive("halt_br",   5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1853, 5'd8, 4'hA, 4'h7, 1'b0, 1'b1, 1'b0);
        drive("halt_disp", 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1853, 5'd8, 4'hA, 4'h7, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            drive("halt_mem", 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 5'd8, 4'hA, 4'h7, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        check("end", "queue_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter FETCH_ADDR, default 5'd0: microaddress of instruction-fetch routine.
REQ-002 Parameter DISP_BASE, default 5'd2: base added to opcode on dispatch.
REQ-003 Parameter MEM_TIMEOUT, default 8'd255: wait cycles before memory access is abandoned.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 NXTADD  input  5  next-address field of current control word.
REQ-007 BR  input  1  conditional-branch enable of current control word.
REQ-008 Z  input  1  ALU zero flag.
REQ-009 MEMREAD, MEMWR  input  1 each  memory access requested by current control word.
REQ-010 MEMDONE  input  1  memory completion acknowledge.
REQ-011 IR  input  16  instruction register; [15:11] opcode, [7:4] write-reg select, [3:0] read-reg select.
REQ-012 ROMADDR  output  5  microprogram ROM address (micro-PC).
REQ-013 WR, RR  output  4 each  registered write/read register selects for the control-signal block.
REQ-014 STALL  output  1  high while waiting on memory.
REQ-015 HALTED  output  1  high in HALT state.
REQ-016 MEMERR  output  1  sticky memory-timeout flag.

Function
REQ-017 States RUN, WAIT, HALT; 8-bit wait counter CNT; micro-PC UPC drives ROMADDR directly.
REQ-018 Next-address rule (NEXT): BR=1 -> Z=1 ? NXTADD : UPC+1 (mod 32); BR=0 and NXTADD!=5'd31 -> NXTADD; BR=0 and NXTADD==5'd31 -> dispatch.
REQ-019 Dispatch: opcode 5'b11111 -> state HALT, UPC unchanged; otherwise UPC <= IR[15:11]+DISP_BASE (mod 32), WR <= IR[7:4], RR <= IR[3:0] in same edge.
REQ-020 WR/RR change only on a non-HALT dispatch; otherwise hold.
REQ-021 RUN, MEMREAD|MEMWR=0 -> UPC <= NEXT.
REQ-022 RUN, MEMREAD|MEMWR=1, MEMDONE=1 -> UPC <= NEXT (zero-wait access).
REQ-023 RUN, MEMREAD|MEMWR=1, MEMDONE=0 -> state WAIT, CNT <= 1, UPC held.
REQ-024 WAIT, MEMDONE=1 -> state RUN, CNT <= 0, UPC <= NEXT using BR/Z/NXTADD/IR sampled on that edge.
REQ-025 WAIT, MEMDONE=0, CNT==MEM_TIMEOUT -> state RUN, UPC <= FETCH_ADDR, MEMERR <= 1, CNT <= 0.
REQ-026 WAIT, MEMDONE=0, CNT<MEM_TIMEOUT -> CNT <= CNT+1, UPC held.
REQ-027 MEMDONE=1 on the timeout edge -> completion wins (REQ-024); MEMERR unchanged.
REQ-028 Dispatch requested by a memory-access word occurs only at memory completion; IR sampled then.
REQ-029 HALT is terminal: UPC, WR, RR, CNT held; all inputs ignored until reset.
REQ-030 STALL = (state==WAIT), HALTED = (state==HALT), both decoded combinationally from state registers.
REQ-031 MEMERR, once set, stays 1 until reset.
REQ-032 MEMDONE outside WAIT/RUN-with-access is ignored.

Reset
REQ-033 rstn=0 asynchronously forces UPC=FETCH_ADDR, WR=0, RR=0, CNT=0, MEMERR=0, state RUN; STALL=0, HALTED=0.
REQ-034 Reset asserted in WAIT or HALT aborts immediately with the same values; first post-reset posedge evaluates RUN rules.

Verification
REQ-035 Reset release, BR=0, NXTADD=5'd7, no access -> ROMADDR 0 then 7 after one posedge.
REQ-036 UPC=5'd9, BR=1: Z=0 -> ROMADDR 10; repeat from 31 with Z=0 -> wraps to 0; Z=1, NXTADD=5'd20 -> 20.
REQ-037 NXTADD=31, BR=0, IR=16'h1853 -> ROMADDR 5 (3+2), WR=4'h5, RR=4'h3; IR=16'hF800 -> HALTED=1, ROMADDR unchanged, further stimulus ignored.
REQ-038 MEMREAD=1, MEMDONE low 3 cycles then high, NXTADD=5'd12 -> STALL high 3 cycles, ROMADDR held, then 12, STALL 0.
REQ-039 MEM_TIMEOUT=8'd4, MEMWR=1, MEMDONE never -> STALL 4 cycles, then ROMADDR=0, MEMERR=1 sticky; repeat with MEMDONE=1 on timeout edge -> MEMERR stays 0.
REQ-040 rstn pulsed low mid-WAIT (CNT=2) -> outputs immediately at REQ-033 values, independent of clk.
